// File: rtl/seg_display_ctrl_if.sv
// ---------------------------------------------------------------------------
// seg_display_ctrl_if
// Value-input handshake bundle for seg_display_ctrl.
//   in_valid  : source offers a new value (held until accepted)
//   in_ready  : controller can accept a value
//   in_value  : 20-bit unsigned value to display
//   dp_mask   : per-digit decimal point enable, bit i = digit i
//   lzb_en    : leading-zero blanking enable
// master = value source, slave = display controller.
// ---------------------------------------------------------------------------
interface seg_display_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_value;
  logic [5:0]  dp_mask;
  logic        lzb_en;

  modport master (output in_valid, in_value, dp_mask, lzb_en, input in_ready);
  modport slave  (input in_valid, in_value, dp_mask, lzb_en, output in_ready);
endinterface

// File: rtl/seg_display_ctrl.sv
// ---------------------------------------------------------------------------
// seg_display_ctrl
// Converts a 20-bit binary value into six active-low 7-segment patterns
// {dp,g,f,e,d,c,b,a} using a 20-cycle shift-add-3 conversion, with
// leading-zero blanking, per-digit decimal points, overflow dashes
// (value > 999999) and whole-display blinking.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_bus (slave)      : in_valid/in_ready handshake, in_value, dp_mask, lzb_en
//   blink_en            : live blink enable
//   done                : one-cycle pulse in the cycle the patterns update
//   seg_data0..seg_data5: digit patterns, seg_data0 = rightmost digit
// ---------------------------------------------------------------------------
module seg_display_ctrl #(
  parameter int CLK_FRE   = 50000000,
  parameter int BLINK_FRE = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  seg_display_ctrl_if.slave   in_bus,
  input  logic                blink_en,
  output logic                done,
  output logic [7:0]          seg_data0,
  output logic [7:0]          seg_data1,
  output logic [7:0]          seg_data2,
  output logic [7:0]          seg_data3,
  output logic [7:0]          seg_data4,
  output logic [7:0]          seg_data5
);

  localparam int HALF_PERIOD = CLK_FRE / (BLINK_FRE * 2);
  localparam int CNT_W       = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  typedef enum logic [1:0] {IDLE, CONV, ENCODE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  bit_cnt;
  logic        accept;

  logic [19:0] bin_p0;
  logic [23:0] bcd_p0;
  logic [23:0] bcd_adj;
  logic [43:0] conv_next;
  logic [5:0]  dp_p0;
  logic        lzb_p0;
  logic        ovf_p0;

  logic [7:0]  pat      [6];
  logic [7:0]  stored   [6];
  logic [7:0]  seg_p1   [6];

  logic [3:0]  dig;
  logic        above_zero;
  logic        blank;
  logic [6:0]  seg7;

  logic [CNT_W-1:0] blink_cnt;
  logic             phase_on;

  // Active-low a..g pattern for one decimal digit.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_to_seg = 7'h40;
      4'd1:    digit_to_seg = 7'h79;
      4'd2:    digit_to_seg = 7'h24;
      4'd3:    digit_to_seg = 7'h30;
      4'd4:    digit_to_seg = 7'h19;
      4'd5:    digit_to_seg = 7'h12;
      4'd6:    digit_to_seg = 7'h02;
      4'd7:    digit_to_seg = 7'h78;
      4'd8:    digit_to_seg = 7'h00;
      4'd9:    digit_to_seg = 7'h10;
      default: digit_to_seg = 7'h3f;
    endcase
  endfunction

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [23:0] add3_all(input logic [23:0] b);
    logic [23:0] r;
    r = b;
    for (int i = 0; i < 6; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign in_bus.in_ready = (state == IDLE);
  assign accept          = in_bus.in_valid && (state == IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CONV;
      CONV:    if (bit_cnt == 5'd0) state_nxt = ENCODE;
      ENCODE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= 5'd0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == ENCODE);
      if (accept)             bit_cnt <= 5'd19;
      else if (state == CONV) bit_cnt <= bit_cnt - 5'd1;
    end
  end

  // ---- stage p0: operand latch and serial conversion ----
  assign bcd_adj   = add3_all(bcd_p0);
  assign conv_next = {bcd_adj, bin_p0} << 1;

  always_ff @(posedge clk) begin
    if (accept) begin
      bin_p0 <= in_bus.in_value;
      bcd_p0 <= 24'd0;
      dp_p0  <= in_bus.dp_mask;
      lzb_p0 <= in_bus.lzb_en;
      ovf_p0 <= (in_bus.in_value > 20'd999999);
    end else if (state == CONV) begin
      {bcd_p0, bin_p0} <= conv_next;
    end
  end

  // Walk from the top digit down; a digit is blanked while it and every
  // digit above it are zero. Digit 0 is never blanked.
  always_comb begin
    above_zero = 1'b1;
    dig        = 4'd0;
    blank      = 1'b0;
    seg7       = 7'h7f;
    for (int i = 5; i >= 0; i--) begin
      dig = bcd_p0[4*i +: 4];
      if (dig != 4'd0) above_zero = 1'b0;
      blank = lzb_p0 && above_zero && (i != 0);
      if (ovf_p0)     seg7 = 7'h3f;
      else if (blank) seg7 = 7'h7f;
      else            seg7 = digit_to_seg(dig);
      pat[i] = {~dp_p0[i], seg7};
    end
  end

  // ---- stage p1: stored patterns and blink-gated outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (blink_cnt == CNT_W'(HALF_PERIOD - 1)) begin
      blink_cnt <= '0;
      phase_on  <= ~phase_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Outputs take the fresh pattern directly in ENCODE so they change on the
  // same edge that raises done, rather than one cycle after the store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) begin
        stored[i] <= 8'hff;
        seg_p1[i] <= 8'hff;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (state == ENCODE) stored[i] <= pat[i];
        if (blink_en && !phase_on) seg_p1[i] <= 8'hff;
        else if (state == ENCODE)  seg_p1[i] <= pat[i];
        else                       seg_p1[i] <= stored[i];
      end
    end
  end

  assign seg_data0 = seg_p1[0];
  assign seg_data1 = seg_p1[1];
  assign seg_data2 = seg_p1[2];
  assign seg_data3 = seg_p1[3];
  assign seg_data4 = seg_p1[4];
  assign seg_data5 = seg_p1[5];

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
- Converts a 20-bit binary value into six 7-segment digit patterns.
- Patterns drive the seg_data0..seg_data5 inputs of the 6-digit multiplexed scan driver.
- Conversion is a sequential shift-add-3 (double-dabble) over 20 cycles.
- Adds leading-zero blanking, per-digit decimal points, overflow indication and whole-display blinking.
- Accepts new values through a valid/ready handshake.

Parameters:
- CLK_FRE, 50000000: clk frequency in Hz.
- BLINK_FRE, 2: blink frequency in Hz (one full on+off period per 1/BLINK_FRE s).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  new value offered.
- in_ready  out  1  block can accept a value.
- in_value  in  20  unsigned binary value to display.
- dp_mask  in  6  bit i set = light decimal point of digit i; sampled at accept.
- lzb_en  in  1  leading-zero blanking enable; sampled at accept.
- blink_en  in  1  live (not sampled) blink enable.
- done  out  1  one-cycle pulse when seg_data outputs update.
- seg_data0..seg_data5  out  8 each  active-low segment pattern {dp,g,f,e,d,c,b,a}; seg_data0 = least significant (rightmost) digit.

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; in_ready=1, done=0.
  - All seg_data outputs 8'hff.
  - Blink counter 0, blink phase ON.
  - A reset mid-conversion aborts it; no done pulse follows.
- State IDLE:
  - in_ready=1.
  - Accept occurs on an edge with in_valid=1 and in_ready=1.
  - On accept, latch in_value, dp_mask and lzb_en; clear the 24-bit BCD register; bit counter=19; go to CONV.
  - in_valid while not ready is ignored; the source holds it.
- State CONV, one bit per cycle, exactly 20 cycles:
  - Each BCD nibble ≥5 gets +3 before the shift.
  - Then shift {bcd,bin} left by 1.
  - Counter reaches 0 → ENCODE.
- State ENCODE, 1 cycle, registers digit patterns:
  - done=1 on the edge the outputs update; return to IDLE on the same edge, so in_ready=1 in the done cycle.
  - Latency: outputs change on the 21st edge after the accept edge.
- Encoding, bits [6:0]:
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90.
  - blank 7F, dash 3F.
  - Bit7 = ~dp_mask[i].
- Overflow: latched value > 999999 → all six digits show dash (8'hbf, or 8'h3f with dp). Latency is unchanged. Leading-zero blanking is not applied.
- Leading-zero blanking (lzb_en=1):
  - Digits above the most significant nonzero digit are blank.
  - Digit 0 is always shown, so value 0 shows a single "0".
  - The dp of a blanked digit still follows dp_mask (8'h7f).
- Blink:
  - Free-running counter wraps at CLK_FRE/(BLINK_FRE*2)-1 and toggles the phase.
  - When blink_en=1 and phase=OFF, all seg_data outputs read 8'hff. Gating is registered, 1 cycle after the condition.
  - blink_en=0 shows the stored patterns within 1 cycle.
  - The counter runs regardless of blink_en.
- A new accept does not blank the display; the old patterns stay until the next ENCODE.

Test Plan:
- Reset, then accept in_value=123456, dp_mask=0, lzb_en=0 → done 21 edges after accept; seg_data5..0 = A4? no: seg5=F9, seg4=A4, seg3=B0, seg2=99, seg1=92, seg0=82.
- Accept 42, lzb_en=1, dp_mask=6'b000010 → seg5..seg2=FF, seg1=19, seg0=A4.
- Accept 0 with lzb_en=1 → seg0=C0, others FF. Then accept 1000000 → all six BF.
- in_valid held high during CONV → in_ready=0, no second accept until the done cycle; back-to-back values 7 then 999999 → both displayed in order, second done 21 edges after second accept.
- CLK_FRE=40, BLINK_FRE=2, blink_en=1 → outputs alternate stored/FF every 10 cycles; blink_en=0 → stored patterns within 1 cycle.
- Assert rst_n low at CONV cycle 10 → outputs FF, in_ready=1 immediately, no done; next accept converts normally.
